// File: rtl/tb_mem_emul_pkg.sv
// tb_mem_emul_pkg: shared constants and helpers for the memory emulator.
package tb_mem_emul_pkg;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic int region_lat(input logic [63:0] addr, input longint unsigned nc_bytes,
                                    input int cached_lat, input int nc_lat);
    return (addr < nc_bytes) ? nc_lat : cached_lat;
  endfunction
  function automatic int timer_width(input int nc_lat);
    return $clog2(nc_lat + 1);
  endfunction
endpackage

// File: rtl/tb_mem_emul_rsp_fifo.sv
// tb_mem_emul_rsp_fifo: in-order response FIFO with per-entry countdown timers.
module tb_mem_emul_rsp_fifo #(
  parameter int DataWidth = 64,
  parameter int IdWidth = 4,
  parameter int Depth = 4,
  parameter int TimerW = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic [IdWidth-1:0]         push_id,
  input  logic [DataWidth-1:0]       push_rdata,
  input  logic                       push_err,
  input  logic [TimerW-1:0]          push_timer,
  input  logic                       pop,
  output logic                       head_ready,
  output logic [IdWidth-1:0]         head_id,
  output logic [DataWidth-1:0]       head_rdata,
  output logic                       head_err,
  output logic [$clog2(Depth+1)-1:0] count
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);
  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] rdata;
    logic                 err;
    logic [TimerW-1:0]    timer;
  } rsp_entry_t;
  rsp_entry_t ent [Depth];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < Depth; i++) ent[i].timer <= '0;
    end else begin
      for (int i = 0; i < Depth; i++)
        if (ent[i].timer != '0) ent[i].timer <= ent[i].timer - 1'b1;
      if (push) begin
        ent[wr_ptr] <= '{push_id, push_rdata, push_err, push_timer};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CntW'(push) - CntW'(pop);
    end
  end
  assign head_ready = (count != '0) && (ent[rd_ptr].timer == '0);
  assign head_id    = ent[rd_ptr].id;
  assign head_rdata = ent[rd_ptr].rdata;
  assign head_err   = ent[rd_ptr].err;
endmodule

// File: rtl/tb_mem_emul.sv
// tb_mem_emul: parametrised in-order memory emulator with region latencies.
// Define TB_MEM_EMUL_STALL_EN to enable LFSR-driven request back-pressure.
module tb_mem_emul
  import tb_mem_emul_pkg::*;
#(
  parameter int DataWidth = 64,
  parameter int AddrWidth = 64,
  parameter int NumWords = 16384,
  parameter int MaxOutstanding = 4,
  parameter int IdWidth = 4,
  parameter int NcBytes = 4096,
  parameter int CachedLatency = 2,
  parameter int NcLatency = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_be_i,
  input  logic [IdWidth-1:0]     req_id_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic [IdWidth-1:0]     rsp_id_o,
  output logic                   rsp_err_o
);
  localparam int OffW = $clog2(DataWidth / 8);
  localparam int IdxW = AddrWidth - OffW;
  localparam int MemW = $clog2(NumWords);
  localparam int TimerW = timer_width(NcLatency);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  logic [DataWidth-1:0] mem [NumWords];
  logic [IdxW-1:0] idx;
  logic [MemW-1:0] widx;
  logic [CntW-1:0] count;
  logic [IdWidth-1:0] head_id;
  logic [DataWidth-1:0] head_rdata, rdata;
  logic [TimerW-1:0] timer;
  logic oor, stall, accept, head_ready, head_err, pop;
`ifdef TB_MEM_EMUL_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk_i) lfsr <= rst_i ? LFSR_SEED : {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  assign stall = lfsr[1:0] == 2'b00;
`else
  assign stall = 1'b0;
`endif
  assign idx    = req_addr_i[AddrWidth-1:OffW];
  assign widx   = idx[MemW-1:0];
  assign oor    = idx >= IdxW'(NumWords);
  assign rdata  = (req_we_i | oor) ? '0 : mem[widx];
  assign timer  = TimerW'(region_lat(64'(req_addr_i), NcBytes, CachedLatency, NcLatency) - 1);
  assign req_ready_o = ~rst_i & (count < CntW'(MaxOutstanding)) & ~stall;
  assign accept = req_valid_i & req_ready_o;
  always_ff @(posedge clk_i)
    if (accept & req_we_i & ~oor)
      for (int b = 0; b < DataWidth / 8; b++)
        if (req_be_i[b]) mem[widx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
  task automatic load(input int unsigned word, input logic [DataWidth-1:0] data);
    mem[word] <= data;
  endtask
  tb_mem_emul_rsp_fifo #(
    .DataWidth(DataWidth), .IdWidth(IdWidth), .Depth(MaxOutstanding), .TimerW(TimerW)
  ) u_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(accept), .push_id(req_id_i), .push_rdata(rdata),
    .push_err(oor), .push_timer(timer), .pop(pop), .head_ready(head_ready),
    .head_id(head_id), .head_rdata(head_rdata), .head_err(head_err), .count(count)
  );
  // Reset forces outputs low combinationally since the FIFO clears only at the edge.
  assign rsp_valid_o = ~rst_i & head_ready;
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_rdata_o = rsp_valid_o ? head_rdata : '0;
  assign rsp_id_o    = rsp_valid_o ? head_id : '0;
  assign rsp_err_o   = rsp_valid_o & head_err;
endmodule

// File: tb/tb_tb_mem_emul.sv
// tb_tb_mem_emul: directed and random checks of tb_mem_emul against a queue model.
module tb_tb_mem_emul;
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_ready, req_we = 0, rsp_valid, rsp_ready = 0, rsp_err;
  logic [63:0] req_addr = 0, req_wdata = 0, rsp_rdata;
  logic [7:0] req_be = 0;
  logic [3:0] req_id = 0, rsp_id;
  always #5 clk = ~clk;
  tb_mem_emul dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .req_id_i(req_id), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_id_o(rsp_id), .rsp_err_o(rsp_err)
  );
  typedef struct {
    logic [3:0]  id;
    logic [63:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t q[$];
  logic [63:0] mm [16384];
  int now, total, bad, t0;
  int pop_cyc [16];
  logic [63:0] last_rd, pre;
  logic last_err;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic we, input logic [63:0] a, input logic [63:0] wd,
                     input logic [7:0] be, input logic [3:0] id, input logic rr);
    logic er, ev, oor;
    logic [63:0] rd;
    longint unsigned idx;
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_be = be; req_id = id;
    rsp_ready = rr;
    #1;
    er = q.size() < 4;
    ev = q.size() > 0 && now >= q[0].due;
    check("req_ready", 64'(req_ready), 64'(er));
    check("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (ev) begin
      check("rsp_id", 64'(rsp_id), 64'(q[0].id));
      check("rsp_rdata", rsp_rdata, q[0].rdata);
      check("rsp_err", 64'(rsp_err), 64'(q[0].err));
      if (rr) begin
        pop_cyc[q[0].id] = now;
        last_rd = rsp_rdata;
        last_err = rsp_err;
        void'(q.pop_front());
      end
    end
    if (v && er) begin
      idx = a >> 3;
      oor = idx >= 16384;
      rd = (we || oor) ? 64'd0 : mm[idx];
      q.push_back('{id, rd, oor, now + ((a < 64'd4096) ? 6 : 2)});
      if (we && !oor)
        for (int b = 0; b < 8; b++) if (be[b]) mm[idx][b*8 +: 8] = wd[b*8 +: 8];
    end
    @(posedge clk);
    now++;
    @(negedge clk);
  endtask
  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, rr);
  endtask
  task automatic do_reset();
    rst = 1; req_valid = 0; rsp_ready = 1;
    #1;
    check("rst_req_ready", 64'(req_ready), 0);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_id", 64'(rsp_id), 0);
    check("rst_rsp_err", 64'(rsp_err), 0);
    @(posedge clk);
    now++;
    @(negedge clk);
    rst = 0;
    q.delete();
  endtask
  function automatic logic [63:0] rand_addr();
    int k = $urandom_range(0, 9);
    logic [63:0] lo = 64'($urandom_range(0, 7));
    if (k < 4) return 64'($urandom_range(0, 31)) * 8 + lo;
    if (k < 9) return 64'h2000 + 64'($urandom_range(0, 31)) * 8 + lo;
    return 64'h20000 + 64'($urandom_range(0, 3)) * 8 + lo;
  endfunction
  initial begin
    for (int i = 0; i < 16384; i++) begin
      mm[i] = {$urandom, $urandom};
      dut.load(i, mm[i]);
    end
    @(negedge clk);
    do_reset();
    t0 = now;
    cyc(1, 0, 64'h2000, 0, 0, 4'd3, 1);
    idle(4, 1);
    check("cached_lat", 64'(pop_cyc[3] - t0), 2);
    check("cached_rdata", last_rd, mm[1024]);
    pre = mm[1025];
    cyc(1, 1, 64'h2008, 64'h1122334455667788, 8'h0F, 4'd5, 1);
    cyc(1, 0, 64'h2008, 0, 0, 4'd6, 1);
    idle(4, 1);
    check("rmw_rdata", last_rd, {pre[63:32], 32'h55667788});
    t0 = now;
    cyc(1, 0, 64'h0100, 0, 0, 4'd1, 1);
    cyc(1, 0, 64'h3000, 0, 0, 4'd2, 1);
    idle(8, 1);
    check("nc_lat", 64'(pop_cyc[1] - t0), 6);
    check("in_order", 64'(pop_cyc[2] - t0), 7);
    for (int i = 0; i < 5; i++) cyc(1, 0, 64'h2000 + 64'(i) * 8, 0, 0, 4'(4 + i), 0);
    cyc(1, 0, 64'h2020, 0, 0, 4'd8, 1);
    cyc(1, 0, 64'h2020, 0, 0, 4'd8, 0);
    idle(10, 1);
    cyc(1, 0, 64'h20000, 0, 0, 4'd9, 1);
    idle(3, 1);
    check("oor_err", 64'(last_err), 1);
    cyc(1, 1, 64'h20000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4'd10, 1);
    cyc(1, 0, 64'h0, 0, 0, 4'd11, 1);
    idle(8, 1);
    check("oor_no_alias", last_rd, mm[0]);
    for (int i = 0; i < 3; i++) cyc(1, 0, 64'h2040 + 64'(i) * 8, 0, 0, 4'(12 + i), 0);
    idle(2, 0);
    do_reset();
    cyc(1, 0, 64'h2010, 0, 0, 4'd15, 1);
    idle(4, 1);
    check("post_rst_rdata", last_rd, mm[1026]);
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, rand_addr(),
          {$urandom, $urandom}, 8'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
    idle(12, 1);
    check("drained", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
